// File: rtl/rhythm_game_ctrl.sv
// rtl/rhythm_game_ctrl.sv - session and hit-judge controller for the note-scroll shifter
//
// Purpose: runs the IDLE -> PLAY -> RESULT session, judges red/blue presses
// against the shifter judge slot, and keeps score, max combo and miss count.
// Optional feature macro: GHOST_PRESS_PENALTY_EN (when defined, a wrong press
// breaks the combo and counts as a miss; otherwise wrong presses are ignored).
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   btn_red_i, btn_blue_i,
//   btn_yellow_i, btn_sel_i         debounced asynchronous button levels
//   note_R_judge_i, note_B_judge_i  shifter judge-slot contents
//   offset_i                        shifter pixel counter, 0..6
//   finish_i                        shifter end-of-song
//   song_o                          song select to the shifter, 0 = none
//   delete_o                        one-cycle judge-slot clear pulse
//   score_o                         saturating score
//   max_combo_o                     highest combo this session
//   miss_cnt_o                      saturating miss count
//   state_o                         0 IDLE, 1 PLAY, 2 RESULT
//   hit_flash_o                     stretched hit indicator
module rhythm_game_ctrl #(
   parameter int HIT_PTS     = 8,
   parameter int BONUS_COMBO = 10,
   parameter int FLASH_CYC   = 50000,
   parameter int SCORE_W     = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               btn_red_i,
   input  logic               btn_blue_i,
   input  logic               btn_yellow_i,
   input  logic               btn_sel_i,
   input  logic               note_R_judge_i,
   input  logic               note_B_judge_i,
   input  logic [2:0]         offset_i,
   input  logic               finish_i,
   output logic [1:0]         song_o,
   output logic               delete_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [7:0]         max_combo_o,
   output logic [7:0]         miss_cnt_o,
   output logic [1:0]         state_o,
   output logic               hit_flash_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_RESULT = 2'd2
   } state_e;

   localparam logic [SCORE_W:0] PTS_NORM   = (SCORE_W+1)'(HIT_PTS);
   localparam logic [SCORE_W:0] PTS_BONUS  = (SCORE_W+1)'(2 * HIT_PTS);
   localparam logic [7:0]       BONUS_MIN  = 8'(BONUS_COMBO);
   localparam logic [15:0]      FLASH_LOAD = 16'(FLASH_CYC);

   // Button vectors are ordered {sel, yellow, blue, red}.
   logic [3:0]         sync1_q, sync2_q, prev_q, rise_q;
   logic [2:0]         offset_q;
   logic               judge_q;

   state_e             state_q, state_d;
   logic [1:0]         sel_idx_q, sel_idx_d;
   logic [1:0]         song_q, song_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [7:0]         combo_q, combo_d;
   logic [7:0]         max_combo_q, max_combo_d;
   logic [7:0]         miss_q, miss_d;
   logic               slot_hit_q, slot_hit_d;
   logic               delete_q, delete_d;
   logic [15:0]        flash_q, flash_d;

   logic               advance, hit, wrong, pass_miss;
   logic [1:0]         miss_inc;
   logic [SCORE_W:0]   score_sum;
   logic [8:0]         miss_sum;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q     <= 4'd0;
         sync2_q     <= 4'd0;
         prev_q      <= 4'd0;
         rise_q      <= 4'd0;
         offset_q    <= 3'd0;
         judge_q     <= 1'b0;
         state_q     <= ST_IDLE;
         sel_idx_q   <= 2'd1;
         song_q      <= 2'd0;
         score_q     <= '0;
         combo_q     <= 8'd0;
         max_combo_q <= 8'd0;
         miss_q      <= 8'd0;
         slot_hit_q  <= 1'b0;
         delete_q    <= 1'b0;
         flash_q     <= 16'd0;
      end else begin
         sync1_q     <= {btn_sel_i, btn_yellow_i, btn_blue_i, btn_red_i};
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         // Edge is registered so the judge inputs are sampled in the cycle
         // the press becomes visible, one edge before delete.
         rise_q      <= sync2_q & ~prev_q;
         offset_q    <= offset_i;
         judge_q     <= note_R_judge_i | note_B_judge_i;
         state_q     <= state_d;
         sel_idx_q   <= sel_idx_d;
         song_q      <= song_d;
         score_q     <= score_d;
         combo_q     <= combo_d;
         max_combo_q <= max_combo_d;
         miss_q      <= miss_d;
         slot_hit_q  <= slot_hit_d;
         delete_q    <= delete_d;
         flash_q     <= flash_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_idx_d   = sel_idx_q;
      song_d      = song_q;
      score_d     = score_q;
      combo_d     = combo_q;
      max_combo_d = max_combo_q;
      miss_d      = miss_q;
      slot_hit_d  = slot_hit_q;
      delete_d    = 1'b0;
      flash_d     = (flash_q != 16'd0) ? flash_q - 16'd1 : 16'd0;
      advance     = (offset_q == 3'd6) && (offset_i == 3'd0);
      hit         = 1'b0;
      wrong       = 1'b0;
      pass_miss   = 1'b0;
      miss_inc    = 2'd0;
      score_sum   = '0;
      miss_sum    = 9'd0;

      case (state_q)
         ST_IDLE: begin
            song_d = 2'd0;
            if (rise_q[3]) begin
               sel_idx_d = (sel_idx_q == 2'd3) ? 2'd1 : sel_idx_q + 2'd1;
            end
            if (rise_q[2]) begin
               song_d      = sel_idx_q;
               score_d     = '0;
               combo_d     = 8'd0;
               max_combo_d = 8'd0;
               miss_d      = 8'd0;
               slot_hit_d  = 1'b0;
               state_d     = ST_PLAY;
            end
         end

         ST_PLAY: begin
            if (finish_i) begin
               state_d = ST_RESULT;
               song_d  = 2'd0;
            end else begin
               // Red and blue together can never be a hit.
               hit = (rise_q[0] ^ rise_q[1]) & ~slot_hit_q &
                     ((rise_q[0] & note_R_judge_i) | (rise_q[1] & note_B_judge_i));
`ifdef GHOST_PRESS_PENALTY_EN
               wrong = (rise_q[0] | rise_q[1]) & ~hit;
`else
               wrong = 1'b0;
`endif
               // A hit in the advance cycle judges the incoming slot, so it
               // suppresses the pass-miss and leaves slot_hit set.
               pass_miss = advance & judge_q & ~slot_hit_q & ~hit;
               if (hit) begin
                  delete_d  = 1'b1;
                  score_sum = {1'b0, score_q} +
                              ((combo_q >= BONUS_MIN) ? PTS_BONUS : PTS_NORM);
                  score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                  combo_d   = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
                  if (combo_d > max_combo_q) begin
                     max_combo_d = combo_d;
                  end
                  slot_hit_d = 1'b1;
                  flash_d    = FLASH_LOAD;
               end else if (advance) begin
                  slot_hit_d = 1'b0;
               end
               if (pass_miss | wrong) begin
                  combo_d = 8'd0;
               end
               miss_inc = {1'b0, pass_miss} + {1'b0, wrong};
               miss_sum = {1'b0, miss_q} + {7'd0, miss_inc};
               miss_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
            end
         end

         ST_RESULT: begin
            song_d = 2'd0;
            if (rise_q[2]) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            song_d  = 2'd0;
         end
      endcase
   end

   assign song_o      = song_q;
   assign delete_o    = delete_q;
   assign score_o     = score_q;
   assign max_combo_o = max_combo_q;
   assign miss_cnt_o  = miss_q;
   assign state_o     = state_q;
   assign hit_flash_o = (flash_q != 16'd0);

endmodule
